// File: rtl/stack_pkg.sv
// Shared stack definitions: op encodings (also used by the return stack) and
// the spill/fill FSM state encodings.
package stack_pkg;

  // Bit positions inside a 4-bit stack op.
  localparam int unsigned POP   = 3;
  localparam int unsigned PUSH  = 2;
  localparam int unsigned WRITE = 1;
  localparam int unsigned READ  = 0;

  localparam logic [3:0] SOP_IDLE  = 4'b0000;
  localparam logic [3:0] SOP_PUSH  = 4'b0110;
  localparam logic [3:0] SOP_POP   = 4'b1001;
  localparam logic [3:0] SOP_WRITE = 4'b0010;

  // Spill controller states.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_FILL = 2'b01;
  localparam logic [1:0] ST_LOAD = 2'b10;

endpackage

// File: rtl/data_stack_if.sv
// Data stack bus: controller side (op, overwrite data, top-of-stack view,
// status) and data-memory side (spill writes, fill reads).
//   master: controller + memory model drive op/to_sr*/overwrites/mem_rdata
//   slave : the stack drives from_sr*, status and mem_* strobes
interface data_stack_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 10
);
  logic [3:0]        op;
  logic [WIDTH-1:0]  to_sr0;
  logic [WIDTH-1:0]  to_sr1;
  logic              sr0_overwrite;
  logic              sr1_overwrite;
  logic [WIDTH-1:0]  from_sr0;
  logic [WIDTH-1:0]  from_sr1;
  logic              overflow;
  logic              busy;
  logic [ADDR_W+3:0] count;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [WIDTH-1:0]  mem_rdata;
  logic [1:0]        err;

  modport master (
    output op, to_sr0, to_sr1, sr0_overwrite, sr1_overwrite, mem_rdata,
    input  from_sr0, from_sr1, overflow, busy, count,
           mem_addr, mem_wdata, mem_we, mem_re, err
  );

  modport slave (
    input  op, to_sr0, to_sr1, sr0_overwrite, sr1_overwrite, mem_rdata,
    output from_sr0, from_sr1, overflow, busy, count,
           mem_addr, mem_wdata, mem_we, mem_re, err
  );
endinterface

// File: rtl/stack_spill_ctrl.sv
// Spill/fill controller: owns the spill pointer, the FILL/LOAD sequence and
// the data-memory strobes.
//   spill_c    : push at full on-chip depth, bottom entry must go to memory
//   pop_full_c : pop accepted while on-chip storage was full
//   bottom     : current bottom on-chip entry (spill data)
//   load_c     : high in LOAD; stack captures mem_rdata into the bottom slot
//   mem_full_c : spill pointer at its last address, further spills drop data
module stack_spill_ctrl
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              async_reset,
  input  logic              spill_c,
  input  logic              pop_full_c,
  input  logic [WIDTH-1:0]  bottom,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic              busy,
  output logic              load_c,
  output logic              mem_full_c
);

  logic [1:0]        state_q,     state_d;
  logic [ADDR_W-1:0] spill_ptr_q, spill_ptr_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic              mem_we_q,    mem_we_d;
  logic              mem_re_q,    mem_re_d;
  logic              busy_q,      busy_d;

  assign mem_full_c = (spill_ptr_q == '1);
  assign load_c     = (state_q == ST_LOAD);

  // Next-state and strobe generation; strobes are registered one cycle wide.
  always_comb begin
    state_d     = state_q;
    spill_ptr_d = spill_ptr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (spill_c && !mem_full_c) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = spill_ptr_q;
          mem_wdata_d = bottom;
          spill_ptr_d = spill_ptr_q + ADDR_W'(1);
        end else if (pop_full_c && (spill_ptr_q != '0)) begin
          state_d    = ST_FILL;
          mem_re_d   = 1'b1;
          mem_addr_d = spill_ptr_q - ADDR_W'(1);
        end
      end
      ST_FILL: state_d = ST_LOAD;
      ST_LOAD: begin
        state_d     = ST_IDLE;
        spill_ptr_d = spill_ptr_q - ADDR_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state_q     <= ST_IDLE;
      spill_ptr_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      spill_ptr_q <= spill_ptr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign busy      = busy_q;

endmodule

// File: rtl/data_stack.sv
// Hardware data stack: DEPTH on-chip entries (entry 0 = top) with spill to
// and automatic refill from data memory.
//   clk, async_reset : clock, asynchronous active-high reset
//   bus (slave)      : op/overwrite commands, sr0/sr1 view, count, status,
//                      data-memory port
module data_stack
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 10
) (
  input  logic         clk,
  input  logic         async_reset,
  data_stack_if.slave  bus
);

  localparam int unsigned OC_W  = $clog2(DEPTH + 1);
  localparam int unsigned CNT_W = ADDR_W + 4;

  logic [WIDTH-1:0] ent_q [DEPTH];
  logic [WIDTH-1:0] ent_d [DEPTH];
  logic [OC_W-1:0]  oc_q,    oc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       err_q,   err_d;

  logic spill_c, pop_full_c, load_c, mem_full_c, busy;
  logic full_c;

  assign full_c = (oc_q == OC_W'(DEPTH));

  // Op first, then overwrites against the post-op occupancy.
  always_comb begin
    ent_d      = ent_q;
    oc_d       = oc_q;
    count_d    = count_q;
    err_d      = err_q;
    spill_c    = 1'b0;
    pop_full_c = 1'b0;
    if (load_c) begin
      ent_d[DEPTH-1] = bus.mem_rdata;
      oc_d           = oc_q + OC_W'(1);
    end else if (!busy) begin
      case (bus.op)
        SOP_PUSH: begin
          for (int i = DEPTH - 1; i > 0; i--) ent_d[i] = ent_q[i-1];
          ent_d[0] = bus.to_sr0;
          if (full_c) begin
            spill_c = 1'b1;
            // Memory full: bottom entry is dropped, so depth is unchanged.
            if (mem_full_c) err_d[1] = 1'b1;
            else            count_d  = count_q + CNT_W'(1);
          end else begin
            oc_d    = oc_q + OC_W'(1);
            count_d = count_q + CNT_W'(1);
          end
        end
        SOP_POP: begin
          if (count_q == '0) begin
            err_d[0] = 1'b1;
          end else begin
            for (int i = 0; i < DEPTH - 1; i++) ent_d[i] = ent_q[i+1];
            ent_d[DEPTH-1] = '0;
            oc_d           = oc_q - OC_W'(1);
            count_d        = count_q - CNT_W'(1);
            pop_full_c     = full_c;
          end
        end
        SOP_WRITE: begin
          if (count_q >= CNT_W'(2)) begin
            ent_d[0] = bus.to_sr0;
            ent_d[1] = bus.to_sr1;
          end
        end
        default: ;
      endcase
      if (bus.sr0_overwrite && (oc_d >= OC_W'(1))) ent_d[0] = bus.to_sr0;
      if (bus.sr1_overwrite && (oc_d >= OC_W'(2))) ent_d[1] = bus.to_sr1;
    end
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      oc_q    <= '0;
      count_q <= '0;
      err_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      oc_q    <= oc_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  stack_spill_ctrl #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_spill (
    .clk        (clk),
    .async_reset(async_reset),
    .spill_c    (spill_c),
    .pop_full_c (pop_full_c),
    .bottom     (ent_q[DEPTH-1]),
    .mem_addr   (bus.mem_addr),
    .mem_wdata  (bus.mem_wdata),
    .mem_we     (bus.mem_we),
    .mem_re     (bus.mem_re),
    .busy       (busy),
    .load_c     (load_c),
    .mem_full_c (mem_full_c)
  );

  assign bus.busy     = busy;
  assign bus.from_sr0 = ent_q[0];
  assign bus.from_sr1 = ent_q[1];
  assign bus.overflow = full_c;
  assign bus.count    = count_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_data_stack.sv
// Directed bench for data_stack with a registered data-memory model.
module tb_data_stack;
  import stack_pkg::*;

  logic clk = 1'b0;
  logic async_reset;
  int   n_vec  = 0;
  int   n_miss = 0;

  data_stack_if #(.WIDTH(16), .ADDR_W(10)) bus ();

  data_stack #(.WIDTH(16), .DEPTH(8), .ADDR_W(10)) dut (
    .clk        (clk),
    .async_reset(async_reset),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  // Data memory: read data valid the cycle after mem_re.
  logic [15:0] mem [1024];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of commands; returns 1 time unit after the edge.
  task automatic step(input logic [3:0] o, input logic [15:0] d0, input logic [15:0] d1,
                      input logic ow0, input logic ow1);
    bus.op            = o;
    bus.to_sr0        = d0;
    bus.to_sr1        = d1;
    bus.sr0_overwrite = ow0;
    bus.sr1_overwrite = ow1;
    @(posedge clk);
    #1;
    bus.op            = SOP_IDLE;
    bus.sr0_overwrite = 1'b0;
    bus.sr1_overwrite = 1'b0;
  endtask

  task automatic push(input logic [15:0] v);
    step(SOP_PUSH, v, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    step(SOP_POP, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    async_reset = 1'b1;
    #2;
    async_reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.op = SOP_IDLE; bus.to_sr0 = '0; bus.to_sr1 = '0;
    bus.sr0_overwrite = 1'b0; bus.sr1_overwrite = 1'b0;
    bus.mem_rdata = '0;
    async_reset = 1'b1;
    #12;
    async_reset = 1'b0;
    @(posedge clk); #1;

    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_sr0",   32'(bus.from_sr0), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_err",   32'(bus.err), 32'd0);
    chk("rst_ovf",   32'(bus.overflow), 32'd0);
    chk("rst_we",    32'(bus.mem_we), 32'd0);

    // Three pushes, no spill.
    push(16'd5); push(16'd7); push(16'd9);
    chk("p3_sr0",   32'(bus.from_sr0), 32'd9);
    chk("p3_sr1",   32'(bus.from_sr1), 32'd7);
    chk("p3_count", 32'(bus.count), 32'd3);
    chk("p3_we",    32'(bus.mem_we), 32'd0);

    // Fill on-chip storage, then spill the ninth.
    do_reset();
    for (int i = 1; i <= 8; i++) push(16'(i));
    chk("p8_ovf", 32'(bus.overflow), 32'd1);
    chk("p8_we",  32'(bus.mem_we), 32'd0);
    push(16'd9);
    chk("p9_we",    32'(bus.mem_we), 32'd1);
    chk("p9_addr",  32'(bus.mem_addr), 32'd0);
    chk("p9_wdata", 32'(bus.mem_wdata), 32'd1);
    chk("p9_ovf",   32'(bus.overflow), 32'd1);
    chk("p9_count", 32'(bus.count), 32'd9);
    chk("p9_sr0",   32'(bus.from_sr0), 32'd9);
    step(SOP_IDLE, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("p9_we_off", 32'(bus.mem_we), 32'd0);

    // Pop with refill; a push during busy must be ignored.
    pop();
    chk("fill_re",    32'(bus.mem_re), 32'd1);
    chk("fill_addr",  32'(bus.mem_addr), 32'd0);
    chk("fill_busy",  32'(bus.busy), 32'd1);
    chk("fill_sr0",   32'(bus.from_sr0), 32'd8);
    chk("fill_count", 32'(bus.count), 32'd8);
    push(16'd99);
    chk("load_busy",  32'(bus.busy), 32'd1);
    chk("load_re",    32'(bus.mem_re), 32'd0);
    chk("load_sr0",   32'(bus.from_sr0), 32'd8);
    chk("load_count", 32'(bus.count), 32'd8);
    step(SOP_IDLE, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("done_busy",  32'(bus.busy), 32'd0);
    chk("done_ovf",   32'(bus.overflow), 32'd1);
    chk("done_count", 32'(bus.count), 32'd8);
    for (int i = 0; i < 7; i++) pop();
    chk("drain_sr0",   32'(bus.from_sr0), 32'd1);
    chk("drain_sr1",   32'(bus.from_sr1), 32'd0);
    chk("drain_count", 32'(bus.count), 32'd1);

    // Write (swap) and overwrites.
    do_reset();
    push(16'd4); push(16'd3);
    step(SOP_WRITE, 16'd4, 16'd3, 1'b0, 1'b0);
    chk("wr_sr0",   32'(bus.from_sr0), 32'd4);
    chk("wr_sr1",   32'(bus.from_sr1), 32'd3);
    chk("wr_count", 32'(bus.count), 32'd2);
    step(SOP_IDLE, 16'h00AA, 16'h0, 1'b1, 1'b0);
    chk("ow0_sr0",   32'(bus.from_sr0), 32'h00AA);
    chk("ow0_count", 32'(bus.count), 32'd2);
    step(SOP_PUSH, 16'h0011, 16'h0022, 1'b0, 1'b1);
    chk("pushow_sr0", 32'(bus.from_sr0), 32'h0011);
    chk("pushow_sr1", 32'(bus.from_sr1), 32'h0022);
    chk("pushow_cnt", 32'(bus.count), 32'd3);

    // Write needs two entries; overwrite of an empty slot is ignored.
    do_reset();
    push(16'd1);
    step(SOP_WRITE, 16'd5, 16'd6, 1'b0, 1'b0);
    chk("wr1_sr0",   32'(bus.from_sr0), 32'd1);
    chk("wr1_sr1",   32'(bus.from_sr1), 32'd0);
    step(SOP_IDLE, 16'h0, 16'h0055, 1'b0, 1'b1);
    chk("ow1_empty", 32'(bus.from_sr1), 32'd0);
    step(4'b1111, 16'h0077, 16'h0, 1'b0, 1'b0);
    chk("illegal_op_sr0", 32'(bus.from_sr0), 32'd1);
    chk("illegal_op_cnt", 32'(bus.count), 32'd1);

    // Underflow.
    do_reset();
    pop();
    chk("uf_err",   32'(bus.err), 32'd1);
    chk("uf_count", 32'(bus.count), 32'd0);
    chk("uf_sr0",   32'(bus.from_sr0), 32'd0);

    // Reset during FILL.
    do_reset();
    for (int i = 1; i <= 9; i++) push(16'(i));
    pop();
    chk("rf_busy_pre", 32'(bus.busy), 32'd1);
    async_reset = 1'b1;
    #1;
    chk("rf_busy",  32'(bus.busy), 32'd0);
    chk("rf_re",    32'(bus.mem_re), 32'd0);
    chk("rf_count", 32'(bus.count), 32'd0);
    chk("rf_err",   32'(bus.err), 32'd0);
    #1;
    async_reset = 1'b0;
    @(posedge clk); #1;
    push(16'h0042);
    chk("rf_after_sr0", 32'(bus.from_sr0), 32'h0042);
    chk("rf_after_cnt", 32'(bus.count), 32'd1);

    // Memory full: 8 on-chip + 1023 spilled, next push drops the bottom.
    do_reset();
    for (int i = 1; i <= 1031; i++) push(16'(i));
    chk("mf_last_we",   32'(bus.mem_we), 32'd1);
    chk("mf_last_addr", 32'(bus.mem_addr), 32'd1022);
    chk("mf_count",     32'(bus.count), 32'd1031);
    chk("mf_err0",      32'(bus.err), 32'd0);
    push(16'd1032);
    chk("mf_err",    32'(bus.err), 32'd2);
    chk("mf_we",     32'(bus.mem_we), 32'd0);
    chk("mf_count2", 32'(bus.count), 32'd1031);
    chk("mf_sr0",    32'(bus.from_sr0), 32'd1032);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/data_stack.md
Name: data_stack

Overview:
- Hardware data stack that responds to the controller's DSOP/to_sr0/to_sr1/overwrite commands.
- Exposes the top two entries (sr0, sr1) to the ALU and the controller.
- Holds DEPTH entries on-chip. When on-chip storage is full, the oldest entries spill to data memory; they are filled back automatically when pops drain the on-chip entries.
- Sits between the control FSM and the data memory port.

Parameters:
- WIDTH, 16, data word width.
- DEPTH, 8, on-chip entries including sr0/sr1; must be at least 2.
- ADDR_W, 10, data memory address width.

Ports:
- clk  in  1  clock
- async_reset  in  1  asynchronous, active-high reset
- op  in  4  stack op: [3] pop, [2] push, [1] write, [0] read
- to_sr0  in  WIDTH  data for push, write, or sr0 overwrite
- to_sr1  in  WIDTH  data for write or sr1 overwrite
- sr0_overwrite  in  1  replace entry 0 with to_sr0; depth unchanged
- sr1_overwrite  in  1  replace entry 1 with to_sr1; depth unchanged
- from_sr0  out  WIDTH  entry 0 (top of stack)
- from_sr1  out  WIDTH  entry 1
- overflow  out  1  on-chip storage full (count == DEPTH)
- busy  out  1  fill in progress; ops ignored
- count  out  ADDR_W+4  total entries (on-chip + spilled)
- mem_addr  out  ADDR_W  data memory address
- mem_wdata  out  WIDTH  spill data
- mem_we  out  1  one-cycle write strobe
- mem_re  out  1  one-cycle read strobe
- mem_rdata  in  WIDTH  read data, valid 1 cycle after mem_re
- err  out  2  sticky: [0] underflow, [1] memory full

Behaviour:
- Reset, asynchronous: all entries, on-chip count, spill pointer, count, err, mem_* and busy go to 0; state goes to IDLE.
- Legal op values: 0000 idle, 0110 push, 1001 pop, 0010 write. Every other op value is a no-op.
- Overwrite priority: op is applied first, then sr0_overwrite/sr1_overwrite in the same cycle. An overwrite on an empty slot is ignored.
- Push:
  - Shifts entries down and loads to_sr0 into entry 0.
  - If on-chip count == DEPTH: entry DEPTH-1 goes to mem_wdata, mem_addr = spill_ptr, mem_we = 1 for that cycle, and spill_ptr increments. The push completes in one cycle.
- Pop:
  - Shifts entries up and decrements count.
  - If spill_ptr > 0 and on-chip count was DEPTH: enter FILL. In FILL, mem_re = 1 and mem_addr = spill_ptr-1, busy = 1. The next cycle, mem_rdata loads into entry DEPTH-1, spill_ptr decrements, and the FSM returns to IDLE.
  - Fill latency: 2 cycles. busy is high for both cycles.
- Write (0010): entry 0 <= to_sr0 and entry 1 <= to_sr1 (used for swap). Requires count >= 2; otherwise no-op.
- Outputs from_sr0 and from_sr1 are registered-entry reads and reflect an op on the cycle after it. An empty slot reads 0.
- Underflow: pop with count == 0 sets err[0]; stack is unchanged.
- Memory full: a spill with spill_ptr == 2^ADDR_W-1 sets err[1]. The bottom entry is dropped, spill_ptr saturates, and count does not increment past its saturated value.
- Ops asserted while busy = 1 are ignored. The controller must hold ops off until busy falls.
- overflow is combinational from the on-chip count.
- Reset during FILL aborts the fill. mem_re drops immediately.
- FSM states:
  - IDLE -> FILL on a pop needing refill.
  - FILL -> LOAD.
  - LOAD -> IDLE.
  - busy = 1 in FILL and LOAD; mem_re = 1 in FILL only.

Decomposition:
- Shared package stack_pkg:
  - SOP bit indices POP=3, PUSH=2, WRITE=1, READ=0.
  - Op constants SOP_IDLE, SOP_PUSH = 4'b0110, SOP_POP = 4'b1001, SOP_WRITE = 4'b0010.
  - FSM state encodings.
- The same SOP constants also serve the return stack.
- One natural sub-module: stack_spill_ctrl, holding spill_ptr, the FILL/LOAD FSM and the memory strobes. The shift register stays in data_stack.

Test Plan:
- Push 5, 7, 9 -> from_sr0 = 9, from_sr1 = 7, count = 3, no mem_we.
- With DEPTH = 8, push 1..9 -> on the 9th push: mem_we = 1, mem_addr = 0, mem_wdata = 1. Afterwards overflow = 1, count = 9, from_sr0 = 9.
- Continue from the 9-entry stack and pop -> mem_re = 1 at addr 0; busy high 2 cycles; entry 7 = 1 afterwards; from_sr0 = 8; count = 8.
- Stack (3, 4), op = 0010 with to_sr0 = 4, to_sr1 = 3 -> from_sr0 = 4, from_sr1 = 3; count unchanged. Also sr0_overwrite with to_sr0 = 0x00AA -> from_sr0 = 0x00AA; count unchanged.
- Pop on empty stack -> err[0] = 1, count = 0, from_sr0 = 0. Push attempted during busy -> ignored.
- Assert async_reset during FILL -> busy = 0, mem_re = 0, count = 0, state IDLE on the same edge.
